// File: rtl/latch_arb_pkg.sv
// Shared types for the latch bank arbiter: FSM state encoding and a
// width helper for requester indices.
package latch_arb_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_OPEN  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_ACK   = 3'd4
   } state_t;

   // Index width for N requesters, never narrower than one bit.
   function automatic int clog2n(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] winner_o,
   output logic          valid_o
);

   int            sum;
   logic [IW-1:0] idx;

   // Scanning from the far end lets the candidate closest to ptr_i overwrite the rest.
   always_comb begin
      valid_o  = 1'b0;
      winner_o = '0;
      sum      = 0;
      idx      = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum = (int'(ptr_i) + i) % N;
         idx = IW'(sum);
         if (req_i[idx]) begin
            valid_o  = 1'b1;
            winner_o = idx;
         end
      end
   end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Round-robin owner of a shared gated-latch bank: drives data, pulses the
// common gate with setup/hold margin, then checks read-back and acknowledges.
module latch_bank_arbiter
   import latch_arb_pkg::*;
#(
   parameter int N           = 4,
   parameter int W           = 8,
   parameter int OPEN_CYCLES = 1,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic [N*W-1:0]        wdata,
   input  logic [W-1:0]          latch_q,
   output logic [W-1:0]          latch_d,
   output logic                  latch_en,
   output logic [N-1:0]          gnt,
   output logic [N-1:0]          done,
   output logic [clog2n(N)-1:0]  owner,
   output logic                  busy,
   output logic                  mismatch
);

   localparam int IW      = clog2n(N);
   localparam int CNT_MAX = (OPEN_CYCLES > HOLD_CYCLES) ? OPEN_CYCLES : HOLD_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  data_q, data_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic          en_q;
   logic [IW-1:0] pick_idx;
   logic          pick_valid;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .winner_o (pick_idx),
      .valid_o  (pick_valid)
   );

   // The gate is registered from the next state so it never glitches on a decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         en_q    <= (state_d == ST_OPEN);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_SETUP;
               owner_d = pick_idx;
               data_d  = wdata[pick_idx*W +: W];
            end
         end
         ST_SETUP: begin
            state_d = ST_OPEN;
            cnt_d   = CW'(OPEN_CYCLES - 1);
         end
         ST_OPEN: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = CW'(HOLD_CYCLES - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      busy     = (state_q != ST_IDLE);
      latch_d  = data_q;
      latch_en = en_q;
      owner    = busy ? owner_q : '0;
      gnt      = busy ? (N'(1) << owner_q) : '0;
      done     = (state_q == ST_ACK) ? (N'(1) << owner_q) : '0;
      mismatch = (state_q == ST_ACK) && (latch_q != data_q);
   end

endmodule
